// File: rtl/gauss_hfilt_if.sv
// gauss_hfilt_if: pixel stream bundle for the horizontal Gaussian stage.
//   pix_en/col/r/g/b            : input pixel stream (driven by master)
//   out_valid/out_col/out_r/g/b : filtered output stream (driven by slave)
// master = upstream/consumer side, slave = the filter block itself.
interface gauss_hfilt_if;
    logic        pix_en;
    logic [12:0] col;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        out_valid;
    logic [12:0] out_col;
    logic [7:0]  out_r;
    logic [7:0]  out_g;
    logic [7:0]  out_b;

    modport master (
        output pix_en, col, r, g, b,
        input  out_valid, out_col, out_r, out_g, out_b
    );

    modport slave (
        input  pix_en, col, r, g, b,
        output out_valid, out_col, out_r, out_g, out_b
    );
endinterface

// File: rtl/gauss_hfilt.sv
// gauss_hfilt: horizontal 5-tap [1 4 6 4 1]/16 Gaussian on each 8-bit RGB
// channel, with edge replication at both line ends and a bypass path that
// keeps identical latency (2 clocks from accept/flush edge to out_valid).
// Ports:
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   filt_sel_i   : 1 = filtered, 0 = centre tap passed unchanged
//   seq_err_o    : sticky column-discontinuity flag (cleared by reset only)
//   px_if        : slave side of the pixel in/out stream bundle
module gauss_hfilt #(
    parameter int LINE_W = 640
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          filt_sel_i,
    output logic          seq_err_o,
    gauss_hfilt_if.slave  px_if
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [12:0] LAST_COL = 13'(LINE_W - 1);
    localparam logic [12:0] PEN_COL  = 13'(LINE_W - 2);

    // One channel of the kernel plus the rounding constant; the largest
    // value is 4080 + 8 = 4088, so 12 bits never overflow.
    function automatic logic [11:0] chan_sum(
        input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
        input logic [7:0] t3, input logic [7:0] t4
    );
        logic [11:0] acc;
        acc = {4'd0, t0} + {2'd0, t1, 2'd0}
            + {3'd0, t2, 1'b0} + {2'd0, t2, 2'd0}
            + {2'd0, t3, 2'd0} + {4'd0, t4} + 12'd8;
        return acc;
    endfunction

    // Stage 0: window, state and emit bookkeeping.
    state_t          state_q, state_d;
    logic [4:0][23:0] win_q, win_d;     // [4] newest, [2] centre
    logic [12:0]     exp_col_q, exp_col_d;
    logic            flush_cnt_q, flush_cnt_d;
    logic            emit_q, emit_d;
    logic [12:0]     ctr_col_q, ctr_col_d;
    logic            seq_err_q, seq_err_d;
    logic [23:0]     pix_s;

    // Stage 1: pre-shift channel values (rounded sum or bypass << 4).
    logic            s1_vld_q;
    logic [12:0]     s1_col_q;
    logic [11:0]     s1_r_q, s1_g_q, s1_b_q;
    logic [11:0]     sum_r_s, sum_g_s, sum_b_s;

    // Stage 2: output registers.
    logic            out_valid_q;
    logic [12:0]     out_col_q;
    logic [7:0]      out_r_q, out_g_q, out_b_q;

    assign pix_s = {px_if.r, px_if.g, px_if.b};

    // Next-state logic for the line-tracking FSM and the tap window.
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        exp_col_d   = exp_col_q;
        flush_cnt_d = flush_cnt_q;
        emit_d      = 1'b0;
        ctr_col_d   = ctr_col_q;
        seq_err_d   = seq_err_q;
        case (state_q)
            ST_IDLE: begin
                if (px_if.pix_en && (px_if.col == 13'd0)) begin
                    win_d     = {5{pix_s}};
                    exp_col_d = 13'd1;
                    state_d   = ST_FILL;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_FILL, ST_RUN: begin
                if (!px_if.pix_en) begin
                    state_d = state_q;
                end else if (px_if.col == exp_col_q) begin
                    win_d     = {pix_s, win_q[4:1]};
                    exp_col_d = exp_col_q + 13'd1;
                    if (state_q == ST_RUN) begin
                        emit_d    = 1'b1;
                        ctr_col_d = px_if.col - 13'd2;
                        if (px_if.col == LAST_COL) begin
                            state_d     = ST_FLUSH;
                            flush_cnt_d = 1'b0;
                        end else begin
                            state_d     = ST_RUN;
                        end
                    end else if (exp_col_q == 13'd2) begin
                        // Third pixel completes the left-replicated window.
                        emit_d    = 1'b1;
                        ctr_col_d = 13'd0;
                        state_d   = ST_RUN;
                    end else begin
                        state_d   = ST_FILL;
                    end
                end else begin
                    // Discontinuity: the offending pixel is judged as if
                    // we were already idle, so col 0 restarts at once.
                    seq_err_d = 1'b1;
                    if (px_if.col == 13'd0) begin
                        win_d     = {5{pix_s}};
                        exp_col_d = 13'd1;
                        state_d   = ST_FILL;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (px_if.pix_en && (px_if.col == 13'd0)) begin
                    // Early start of the next line drops the rest of the flush.
                    win_d     = {5{pix_s}};
                    exp_col_d = 13'd1;
                    state_d   = ST_FILL;
                end else begin
                    win_d     = {win_q[4], win_q[4:1]};
                    emit_d    = 1'b1;
                    ctr_col_d = PEN_COL + {12'd0, flush_cnt_q};
                    if (flush_cnt_q) begin
                        state_d     = ST_IDLE;
                    end else begin
                        flush_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stage 0 registers: FSM state, taps, emit flag and centre column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            win_q       <= 120'd0;
            exp_col_q   <= 13'd0;
            flush_cnt_q <= 1'b0;
            emit_q      <= 1'b0;
            ctr_col_q   <= 13'd0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            exp_col_q   <= exp_col_d;
            flush_cnt_q <= flush_cnt_d;
            emit_q      <= emit_d;
            ctr_col_q   <= ctr_col_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign sum_r_s = chan_sum(win_q[0][23:16], win_q[1][23:16], win_q[2][23:16],
                              win_q[3][23:16], win_q[4][23:16]);
    assign sum_g_s = chan_sum(win_q[0][15:8], win_q[1][15:8], win_q[2][15:8],
                              win_q[3][15:8], win_q[4][15:8]);
    assign sum_b_s = chan_sum(win_q[0][7:0], win_q[1][7:0], win_q[2][7:0],
                              win_q[3][7:0], win_q[4][7:0]);

    // Stage 1: register rounded sums, or the centre tap pre-shifted so both
    // paths share the same >>4 in stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_col_q <= 13'd0;
            s1_r_q   <= 12'd0;
            s1_g_q   <= 12'd0;
            s1_b_q   <= 12'd0;
        end else begin
            s1_vld_q <= emit_q;
            s1_col_q <= ctr_col_q;
            if (filt_sel_i) begin
                s1_r_q <= sum_r_s;
                s1_g_q <= sum_g_s;
                s1_b_q <= sum_b_s;
            end else begin
                s1_r_q <= {win_q[2][23:16], 4'd0};
                s1_g_q <= {win_q[2][15:8], 4'd0};
                s1_b_q <= {win_q[2][7:0], 4'd0};
            end
        end
    end

    // Stage 2: output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_col_q   <= 13'd0;
            out_r_q     <= 8'd0;
            out_g_q     <= 8'd0;
            out_b_q     <= 8'd0;
        end else begin
            out_valid_q <= s1_vld_q;
            out_col_q   <= s1_col_q;
            out_r_q     <= s1_r_q[11:4];
            out_g_q     <= s1_g_q[11:4];
            out_b_q     <= s1_b_q[11:4];
        end
    end

    assign px_if.out_valid = out_valid_q;
    assign px_if.out_col   = out_col_q;
    assign px_if.out_r     = out_r_q;
    assign px_if.out_g     = out_g_q;
    assign px_if.out_b     = out_b_q;
    assign seq_err_o       = seq_err_q;

endmodule

// File: tb/tb_gauss_hfilt.sv
// tb_gauss_hfilt: scoreboard bench for gauss_hfilt. The driver pushes the
// expected output pixel whenever an accepted input makes it computable; a
// forked monitor pops and compares on every out_valid pulse.
module tb_gauss_hfilt;
    localparam int LW = 640;

    typedef struct {
        int col;
        int r;
        int g;
        int b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic filt_sel = 1'b1;
    logic seq_err;
    int   cyc = 0;

    gauss_hfilt_if pif ();

    gauss_hfilt #(.LINE_W(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .filt_sel_i (filt_sel),
        .seq_err_o  (seq_err),
        .px_if      (pif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int   lr [LW];
    int   lg [LW];
    int   lb [LW];
    exp_t sb [$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_pulse = 0;
    bit   lat_armed = 1'b0;
    int   lat_target = 0;

    task automatic check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int tap(int ch, int c);
        int i;
        i = (c < 0) ? 0 : ((c > LW - 1) ? LW - 1 : c);
        case (ch)
            0:       return lr[i];
            1:       return lg[i];
            default: return lb[i];
        endcase
    endfunction

    function automatic int kern(int ch, int c);
        return (tap(ch, c - 2) + 4 * tap(ch, c - 1) + 6 * tap(ch, c)
                + 4 * tap(ch, c + 1) + tap(ch, c + 2) + 8) / 16;
    endfunction

    // mode 0: reference model, 1: flat line constants, 2: impulse table
    function automatic exp_t exp_px(int mode, bit filt, int x);
        exp_t e;
        e.col = x;
        if (mode == 1) begin
            e.r = 100; e.g = 50; e.b = 200;
        end else if (mode == 2) begin
            e.r = (x == 8 || x == 12) ? 10 : (x == 9 || x == 11) ? 40 : (x == 10) ? 60 : 0;
            e.g = 0; e.b = 0;
        end else if (filt) begin
            e.r = kern(0, x); e.g = kern(1, x); e.b = kern(2, x);
        end else begin
            e.r = lr[x]; e.g = lg[x]; e.b = lb[x];
        end
        return e;
    endfunction

    task automatic drive(bit en, int c);
        pif.pix_en = en;
        pif.col    = 13'(c);
        pif.r      = (c < LW) ? 8'(lr[c]) : 8'd0;
        pif.g      = (c < LW) ? 8'(lg[c]) : 8'd0;
        pif.b      = (c < LW) ? 8'(lb[c]) : 8'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        pif.pix_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // flush_mode 0: normal end (638, 639 expected), 1: partial line (none),
    // 2: only 638 expected (caller restarts in the second flush cycle).
    task automatic run_line(int mode, bit filt, bit gaps, int last_c, int flush_mode, bit lat);
        int c = 0;
        int k = 0;
        while (c <= last_c) begin
            if (gaps && !((k % 4 == 0) || (k % 4 == 3))) begin
                drive(1'b0, LW);
            end else begin
                drive(1'b1, c);
                if (lat && c == 2) begin
                    lat_target = cyc + 2;
                    lat_armed  = 1'b1;
                end
                if (c >= 2) sb.push_back(exp_px(mode, filt, c - 2));
                c++;
            end
            k++;
        end
        if (last_c == LW - 1 && flush_mode != 1) sb.push_back(exp_px(mode, filt, LW - 2));
        if (last_c == LW - 1 && flush_mode == 0) sb.push_back(exp_px(mode, filt, LW - 1));
    endtask

    task automatic fill(int seed);
        for (int i = 0; i < LW; i++) begin
            lr[i] = (i * (seed + 1)) & 255;
            lg[i] = (255 - i * 3 + seed * 17) & 255;
            lb[i] = (i * 7 + seed * 29) & 255;
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (pif.out_valid === 1'b1) begin
                n_pulse++;
                if (lat_armed) begin
                    check("first_pulse_latency", cyc, lat_target);
                    lat_armed = 1'b0;
                end
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got out_col %0d, required no pulse", pif.out_col);
                end else begin
                    e = sb.pop_front();
                    check("out_col", int'(pif.out_col), e.col);
                    check("out_r", int'(pif.out_r), e.r);
                    check("out_g", int'(pif.out_g), e.g);
                    check("out_b", int'(pif.out_b), e.b);
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        pif.pix_en = 1'b0;
        pif.col    = 13'd0;
        pif.r      = 8'd0;
        pif.g      = 8'd0;
        pif.b      = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(pif.out_valid), 0);
        check("rst_out_col", int'(pif.out_col), 0);
        check("rst_out_r", int'(pif.out_r), 0);
        check("rst_out_g", int'(pif.out_g), 0);
        check("rst_out_b", int'(pif.out_b), 0);
        check("rst_seq_err", int'(seq_err), 0);
        rst_n = 1'b1;
        idle(2);

        // Flat line with latency and pulse-count checks.
        for (int i = 0; i < LW; i++) begin
            lr[i] = 100; lg[i] = 50; lb[i] = 200;
        end
        n_pulse = 0;
        run_line(1, 1'b1, 1'b0, LW - 1, 0, 1'b1);
        idle(20);
        check("flat_pulse_count", n_pulse, LW);

        // Impulse of 160 at column 10 on red.
        for (int i = 0; i < LW; i++) begin
            lr[i] = 0; lg[i] = 0; lb[i] = 0;
        end
        lr[10] = 160;
        run_line(2, 1'b1, 1'b0, LW - 1, 0, 1'b0);
        idle(10);

        // Ramp: r = col[7:0], exercises both edge replications.
        for (int i = 0; i < LW; i++) begin
            lr[i] = i & 255; lg[i] = (i * 3) & 255; lb[i] = 255 - (i & 255);
        end
        run_line(0, 1'b1, 1'b0, LW - 1, 0, 1'b0);
        idle(10);

        // Bypass with 1,0,0,1 enable pattern.
        filt_sel = 1'b0;
        fill(2);
        run_line(0, 1'b0, 1'b1, LW - 1, 0, 1'b0);
        idle(10);
        filt_sel = 1'b1;
        idle(2);

        // Discontinuity: 0..5 then 9.
        check("seq_err_before_disc", int'(seq_err), 0);
        fill(3);
        run_line(0, 1'b1, 1'b0, 5, 1, 1'b0);
        drive(1'b1, 9);
        check("seq_err_after_disc", int'(seq_err), 1);
        idle(10);
        check("disc_outputs_drained", sb.size(), 0);

        // Normal line after the error; flag stays sticky.
        fill(4);
        run_line(0, 1'b1, 1'b0, LW - 1, 0, 1'b0);
        idle(10);
        check("seq_err_sticky", int'(seq_err), 1);

        // Reset mid-line at column 300.
        fill(5);
        run_line(0, 1'b1, 1'b0, 300, 1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", int'(pif.out_valid), 0);
        check("abort_out_col", int'(pif.out_col), 0);
        check("abort_out_r", int'(pif.out_r), 0);
        check("abort_out_g", int'(pif.out_g), 0);
        check("abort_out_b", int'(pif.out_b), 0);
        check("abort_seq_err", int'(seq_err), 0);
        sb.delete();
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // col 0 in the second flush cycle: 638 emitted, 639 dropped.
        fill(6);
        run_line(0, 1'b1, 1'b0, LW - 1, 2, 1'b0);
        drive(1'b0, LW);
        fill(7);
        run_line(0, 1'b1, 1'b0, LW - 1, 0, 1'b0);
        idle(20);
        check("final_scoreboard_empty", sb.size(), 0);
        check("final_seq_err", int'(seq_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gauss_hfilt.md
# gauss_hfilt

Horizontal 5-tap Gaussian stage for the D8M camera path, placed directly downstream of the row-buffer block (it consumes the delayed-row RGB stream and its column index). The block applies the kernel [1 4 6 4 1]/16 to each 8-bit colour channel independently along a line. Left and right line edges use edge replication, so the output line has exactly the same length as the input line. A bypass select forwards the centre pixel unfiltered with identical latency, so downstream timing does not change when filtering is switched off.

## Interface
- LINE_W, 640: active pixels per line. The last column is LINE_W-1.
- clk  in  1  pixel clock. This is the single clock domain.
- rst_n  in  1  reset: asynchronous, active-low.
- pix_en  in  1  marks the pixel on r/g/b/col as valid this cycle.
- col  in  13  column index of the input pixel, range 0..LINE_W-1.
- r, g, b  in  8 each  input colour channels.
- filt_sel  in  1  1 = filtered output, 0 = bypass (centre tap passed unchanged).
- out_valid  out  1  output pixel is valid this cycle.
- out_col  out  13  column index of the output pixel.
- out_r, out_g, out_b  out  8 each  output channels.
- seq_err  out  1  sticky flag: a column discontinuity was detected. Cleared only by reset.

## Operation
- Window: five 24-bit taps w0..w4, with w4 the newest and w2 the centre. On each accepted pixel the taps shift w0<-w1<-...<-w4 and w4 takes the new pixel.
- Expected column: internal counter exp_col.
- States:
  - IDLE: wait for a pixel with col==0.
  - FILL: columns 0 and 1 accepted, no output.
  - RUN: one output per accepted pixel.
  - FLUSH: two internal shifts at end of line.
- IDLE: accepting col==0 loads all five taps with that pixel, sets exp_col=1, goes to FILL. Any other col is ignored.
- FILL:
  - col==1 shifts in; the window becomes p0,p0,p0,p0,p1.
  - col==2 shifts in; the window becomes p0,p0,p0,p1,p2, goes to RUN, and emits the output for centre column 0.
- RUN: each accepted col==exp_col shifts and emits the output for column col-2. When col==LINE_W-1 is accepted, the block goes to FLUSH.
- FLUSH: runs for two consecutive cycles independent of pix_en. Each cycle shifts w4 into itself (replicating p[LINE_W-1]), emitting columns LINE_W-2 and then LINE_W-1. The block then returns to IDLE.
- Gaps: pix_en low in FILL or RUN holds the window. Nothing is emitted.
- Discontinuity: an accepted col != exp_col in FILL or RUN sets seq_err and moves to IDLE. That pixel is then re-evaluated as an IDLE pixel, so col==0 restarts the line in the same cycle. No output is produced for the bad pixel.
- col==0 accepted during FLUSH: the remaining flush output is dropped, the window is reloaded, and the block goes to FILL. seq_err is not set.
- Arithmetic, per channel: sum = w0 + 4*w1 + 6*w2 + 4*w3 + w4, 12 bits unsigned, maximum 4080. out = (sum+8)>>4. No saturation is needed because the maximum result is 255.
- Bypass: out = centre tap w2. Valid, col and latency are unchanged.

## Timing
- Stage 0: the window and state update on the edge that accepts the pixel (or on a FLUSH edge). An emit flag and centre column are registered alongside.
- Stage 1: the three channel sums (or the bypass copy) are registered on the next edge. filt_sel is sampled at this stage.
- Stage 2: out_r/g/b, out_col and out_valid are registered on the following edge.
- Latency: 2 clocks from the accepting or flush edge to out_valid high. out_valid is a 1-cycle pulse per output pixel.
- Throughput: one pixel per clock, and back-to-back lines are supported. The next col==0 may arrive as early as the cycle right after the second FLUSH cycle.
- Reset:
  - State is IDLE and the taps are 0.
  - out_valid=0, out_col=0, out_r/g/b=0, seq_err=0.
  - Reset asserted mid-line aborts immediately with no further outputs.
  - After release the block waits for col==0.

## Test plan
- Flat line: all pixels (100,50,200) for columns 0..639, contiguous, then 20 idle cycles. Required: exactly 640 out_valid pulses, out_col 0..639 in order, every value (100,50,200), first pulse 2 clocks after the col==2 edge.
- Impulse: r=160 at col 10 and 0 elsewhere. Required: out_r at columns 8..12 equals 10, 40, 60, 40, 10; all other columns 0.
- Edges: r = col[7:0] for a ramp line with LINE_W=640. Required:
  - out col 0 r = (0+0+0+4+2+8)>>4 = 0.
  - out col 639 r: taps (125,126,127,127,127) → (125+504+762+508+127+8)>>4 = 127.
- Gaps and bypass: pix_en toggles 1,0,0,1 across a line with filt_sel=0. Required: out values equal the inputs delayed, and out_col stays contiguous despite the gaps.
- Discontinuity: send col 0..5 then col 9. Required: seq_err=1, no output for columns at or above 4. The next col==0 line filters normally.
- Reset/abort: assert rst_n=0 at col 300. Required: all outputs 0 immediately. Then send col==0 during FLUSH of a following line; required: no out_col 639 pulse for the aborted line, and the new line starts cleanly.
